// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the ID-stage destination tracking and forwarding logic.
package mips_pipe_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EXE  = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [1:0] FWD_LOAD = 2'b11;

   typedef struct packed {
      logic [REG_W-1:0] dest;
      logic             wreg;
      logic             m2reg;
   } dest_entry_t;

   // $0 is hardwired to zero, so a write to it is never a real producer.
   function automatic logic entry_hits(input dest_entry_t e, input logic [REG_W-1:0] src);
      return e.wreg && (e.dest == src) && (src != '0);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ID source register against the EX and MEM producers.
module fwd_sel
   import mips_pipe_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  dest_entry_t      ex_e,
   input  dest_entry_t      mem_e,
   output logic [1:0]       sel,
   output logic             ex_load_hit
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit      = entry_hits(ex_e, src);
   assign mem_hit     = entry_hits(mem_e, src);
   assign ex_load_hit = ex_hit && ex_e.m2reg;

   // Youngest producer wins; a load still in EX has no data yet, so it falls
   // through to MEM (the stall covers that case).
   always_comb begin
      sel = FWD_RF;
      if (ex_hit && !ex_e.m2reg)
         sel = FWD_EXE;
      else if (mem_hit && !mem_e.m2reg)
         sel = FWD_MEM;
      else if (mem_hit && mem_e.m2reg)
         sel = FWD_LOAD;
   end

endmodule

// File: rtl/dest_reg_tracker.sv
// Tracks ID destinations through EX/MEM/WB and derives forwarding selects,
// load-use stall and the register-file write port.
module dest_reg_tracker
   import mips_pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_dest_reg,
   input  logic             id_wreg,
   input  logic             id_m2reg,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_rs_used,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rt_used,
   input  logic             ex_flush,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [REG_W-1:0] ex_dest,
   output logic [REG_W-1:0] mem_dest,
   output logic [REG_W-1:0] wb_dest,
   output logic             wb_wreg
);

   dest_entry_t      ex_q;
   dest_entry_t      mem_q;
   // WB never forwards, so its load flag has no consumer and is not kept.
   logic [REG_W-1:0] wb_dest_q;
   logic             wb_wreg_q;

   logic        a_ld_hit;
   logic        b_ld_hit;
   dest_entry_t id_e;

   assign id_e = '{dest: id_dest_reg, wreg: id_wreg, m2reg: id_m2reg};

   fwd_sel u_fwd_rs (
      .src         (id_rs),
      .ex_e        (ex_q),
      .mem_e       (mem_q),
      .sel         (fwd_a),
      .ex_load_hit (a_ld_hit)
   );

   fwd_sel u_fwd_rt (
      .src         (id_rt),
      .ex_e        (ex_q),
      .mem_e       (mem_q),
      .sel         (fwd_b),
      .ex_load_hit (b_ld_hit)
   );

   // Load-use: a consumer right behind a load must wait one cycle for MEM data.
   always_comb begin
      stall = id_valid && ((id_rs_used && a_ld_hit) || (id_rt_used && b_ld_hit));
   end

   // Advance the tracking pipeline; stalls, flushes and empty slots enter EX as bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_dest_q <= '0;
         wb_wreg_q <= 1'b0;
      end else begin
         wb_dest_q <= mem_q.dest;
         wb_wreg_q <= mem_q.wreg;
         mem_q     <= ex_q;
         if (stall || ex_flush || !id_valid)
            ex_q <= '0;
         else
            ex_q <= id_e;
      end
   end

   assign ex_dest  = ex_q.dest;
   assign mem_dest = mem_q.dest;
   assign wb_dest  = wb_dest_q;
   assign wb_wreg  = wb_wreg_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed and random stimulus against a history-based model of the tracker.
module tb_dest_reg_tracker;

   localparam int RW = 5;

   typedef struct {
      int dest;
      bit wr;
      bit ld;
      bit valid;
      int rs;
      bit rsu;
      int rt;
      bit rtu;
      bit flush;
   } instr_t;

   typedef struct {
      int dest;
      bit wr;
      bit ld;
   } prod_t;

   logic          clk;
   logic          rst_n;
   logic [RW-1:0] id_dest_reg;
   logic          id_wreg;
   logic          id_m2reg;
   logic          id_valid;
   logic [RW-1:0] id_rs;
   logic          id_rs_used;
   logic [RW-1:0] id_rt;
   logic          id_rt_used;
   logic          ex_flush;
   logic          stall;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;
   logic [RW-1:0] ex_dest;
   logic [RW-1:0] mem_dest;
   logic [RW-1:0] wb_dest;
   logic          wb_wreg;

   int n_vec;
   int n_err;

   // history of what entered EX, oldest first; last three are WB, MEM, EX
   prod_t hist[$];

   dest_reg_tracker dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_dest_reg (id_dest_reg),
      .id_wreg     (id_wreg),
      .id_m2reg    (id_m2reg),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rs_used  (id_rs_used),
      .id_rt       (id_rt),
      .id_rt_used  (id_rt_used),
      .ex_flush    (ex_flush),
      .stall       (stall),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .ex_dest     (ex_dest),
      .mem_dest    (mem_dest),
      .wb_dest     (wb_dest),
      .wb_wreg     (wb_wreg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_clear();
      prod_t z;
      z = '{dest: 0, wr: 1'b0, ld: 1'b0};
      hist.delete();
      for (int k = 0; k < 3; k++) hist.push_back(z);
   endfunction

   // A source matches a producer only for a real write to a nonzero register.
   function automatic bit writes(input prod_t p, input int s);
      return p.wr && p.dest == s && s != 0;
   endfunction

   function automatic int ref_fwd(input int s);
      prod_t ex_p;
      prod_t mem_p;
      ex_p  = hist[hist.size()-1];
      mem_p = hist[hist.size()-2];
      if (writes(ex_p, s) && !ex_p.ld) return 1;
      if (writes(mem_p, s)) return mem_p.ld ? 3 : 2;
      return 0;
   endfunction

   function automatic bit ref_stall(input instr_t i);
      prod_t ex_p;
      ex_p = hist[hist.size()-1];
      if (!i.valid || !ex_p.ld) return 1'b0;
      return (i.rsu && writes(ex_p, i.rs)) || (i.rtu && writes(ex_p, i.rt));
   endfunction

   task automatic check_outputs(input instr_t i);
      bit exp_stall;
      exp_stall = ref_stall(i);
      chk_val("stall", 32'(stall), 32'(exp_stall));
      if (!exp_stall) begin
         chk_val("fwd_a", 32'(fwd_a), 32'(ref_fwd(i.rs)));
         chk_val("fwd_b", 32'(fwd_b), 32'(ref_fwd(i.rt)));
      end
      chk_val("ex_dest",  32'(ex_dest),  32'(hist[hist.size()-1].dest));
      chk_val("mem_dest", 32'(mem_dest), 32'(hist[hist.size()-2].dest));
      chk_val("wb_dest",  32'(wb_dest),  32'(hist[hist.size()-3].dest));
      chk_val("wb_wreg",  32'(wb_wreg),  32'(hist[hist.size()-3].wr));
   endtask

   // One ID cycle: drive, check combinational view, clock, advance the model.
   task automatic step(input instr_t i);
      prod_t nxt;
      bit    bub;
      id_dest_reg = RW'(i.dest);
      id_wreg     = i.wr;
      id_m2reg    = i.ld;
      id_valid    = i.valid;
      id_rs       = RW'(i.rs);
      id_rs_used  = i.rsu;
      id_rt       = RW'(i.rt);
      id_rt_used  = i.rtu;
      ex_flush    = i.flush;
      #1;
      check_outputs(i);
      bub = ref_stall(i) || i.flush || !i.valid;
      nxt = bub ? '{dest: 0, wr: 1'b0, ld: 1'b0} : '{dest: i.dest, wr: i.wr, ld: i.ld};
      @(posedge clk);
      if (rst_n) begin
         hist.push_back(nxt);
         void'(hist.pop_front());
      end else begin
         model_clear();
      end
      @(negedge clk);
   endtask

   function automatic instr_t mk(input int d, input bit w, input bit l, input int rs,
                                 input bit rsu, input int rt, input bit rtu, input bit fl);
      instr_t i;
      i = '{dest: d, wr: w, ld: l, valid: 1'b1, rs: rs, rsu: rsu, rt: rt, rtu: rtu, flush: fl};
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i.dest  = int'($urandom_range(0, 3));
      i.wr    = ($urandom_range(0, 9) < 7);
      i.ld    = ($urandom_range(0, 9) < 3);
      i.valid = ($urandom_range(0, 9) < 9);
      i.rs    = int'($urandom_range(0, 3));
      i.rsu   = ($urandom_range(0, 9) < 8);
      i.rt    = int'($urandom_range(0, 3));
      i.rtu   = ($urandom_range(0, 9) < 8);
      i.flush = ($urandom_range(0, 9) == 0);
      return i;
   endfunction

   instr_t dir_q[$];
   instr_t nop;

   initial begin
      n_vec = 0;
      n_err = 0;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);

      // reset held with a live writer at the inputs
      for (int k = 0; k < 3; k++) step(mk(5, 1, 0, 5, 1, 5, 1, 0));
      rst_n = 1'b1;

      dir_q.push_back(mk(8, 1, 0, 0, 0, 0, 0, 0));   // add $8
      dir_q.push_back(mk(0, 0, 0, 8, 1, 0, 0, 0));   // reads rs=$8 -> EX
      dir_q.push_back(mk(0, 0, 0, 0, 0, 8, 1, 0));   // reads rt=$8 -> MEM
      dir_q.push_back(nop);
      dir_q.push_back(mk(9, 1, 1, 0, 0, 0, 0, 0));   // lw $9
      dir_q.push_back(mk(0, 0, 0, 9, 1, 0, 0, 0));   // load-use stall
      dir_q.push_back(mk(0, 0, 0, 9, 1, 0, 0, 0));   // retry -> load data
      dir_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));   // write $0
      dir_q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));   // read $0
      dir_q.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0));
      dir_q.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0));
      dir_q.push_back(mk(0, 0, 0, 3, 1, 0, 0, 0));   // EX beats MEM
      dir_q.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0));
      dir_q.push_back(mk(3, 1, 1, 0, 0, 0, 0, 0));   // lw $3 in EX
      dir_q.push_back(mk(0, 0, 0, 3, 1, 0, 0, 0));   // stall
      dir_q.push_back(mk(4, 1, 1, 0, 0, 0, 0, 1));   // flushed lw $4
      dir_q.push_back(mk(0, 0, 0, 4, 1, 4, 1, 0));   // no stall, no fwd
      for (int k = 0; k < 4; k++) dir_q.push_back(nop);
      foreach (dir_q[k]) step(dir_q[k]);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            #3 rst_n = 1'b0;
            #1;
            model_clear();
            chk_val("rst_ex_dest",  32'(ex_dest),  32'd0);
            chk_val("rst_mem_dest", 32'(mem_dest), 32'd0);
            chk_val("rst_wb_wreg",  32'(wb_wreg),  32'd0);
            @(negedge clk);
            step(rand_instr());
            rst_n = 1'b1;
         end
         step(rand_instr());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dest_reg_tracker.md
Name: dest_reg_tracker

Overview:
Consumer side of the ID-stage destination-register select. Takes the selected destination register (rd or rt) plus its write-enable and load flags, and carries them down a 3-entry EX/MEM/WB tracking pipeline. It compares the tracked entries against the source registers of the instruction currently in ID. From that comparison it produces the ID-stage forwarding selects, the load-use stall, and the write-back destination for the register file.

Parameters:
REG_W, 5, register-index width (32 GPRs)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_dest_reg  input  REG_W  destination register chosen in ID (rd when regrt=0, rt when regrt=1)
id_wreg  input  1  ID instruction writes a GPR
id_m2reg  input  1  ID instruction is a load (result comes from memory)
id_valid  input  1  ID holds a real instruction
id_rs  input  REG_W  ID source A (inst[25:21])
id_rs_used  input  1  ID instruction reads rs
id_rt  input  REG_W  ID source B (inst[20:16])
id_rt_used  input  1  ID instruction reads rt
ex_flush  input  1  squash the instruction entering EX this cycle
stall  output  1  hold PC and IF/ID; bubble into EX
fwd_a  output  2  source-A select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
fwd_b  output  2  source-B select, same encoding as fwd_a
ex_dest  output  REG_W  tracked EX destination
mem_dest  output  REG_W  tracked MEM destination
wb_dest  output  REG_W  register-file write address
wb_wreg  output  1  register-file write enable

Behaviour:
- State: three entries (EX, MEM, WB). Each entry holds {dest[REG_W], wreg, m2reg}.
- Reset (async, rst_n=0): all entries cleared to dest=0, wreg=0, m2reg=0. Outputs after reset: stall=0, fwd_a=fwd_b=00, ex_dest=mem_dest=wb_dest=0, wb_wreg=0.
- Every rising edge (rst_n=1):
  - WB <= MEM and MEM <= EX, unconditionally.
  - EX <= bubble (all zero) when stall=1, ex_flush=1 or id_valid=0.
  - Otherwise EX <= {id_dest_reg, id_wreg, id_m2reg}.
- An entry "hits" source s when: entry.wreg=1, entry.dest==s, and s != 0. Register $0 never hits.
- fwd_a is combinational, in priority order:
  1. EX hit on id_rs with EX.m2reg=0 -> 01.
  2. Else MEM hit with MEM.m2reg=0 -> 10.
  3. Else MEM hit with MEM.m2reg=1 -> 11.
  4. Else 00.
  fwd_b uses the same rules on id_rt.
- A WB entry never forwards. The register file writes in the first half-cycle, so a WB hit reads as 00.
- stall is combinational: id_valid & EX.wreg & EX.m2reg & ((id_rs_used & EX hit on id_rs) | (id_rt_used & EX hit on id_rt)). Duration is exactly one cycle per load-use: the next cycle the load is in MEM, and the select becomes 11.
- When stall=1, fwd_a/fwd_b for the stalled source are don't-care. The bench checks them only when stall=0.
- Unused sources (rs_used/rt_used=0) still compute fwd, but never cause a stall.
- Simultaneous stall and ex_flush: the result is a bubble either way.
- Reset asserted mid-pipeline clears all entries immediately. No write-back occurs while rst_n=0.
- ex_dest, mem_dest, wb_dest and wb_wreg are direct register outputs (zero added latency). Latency from ID to wb_wreg is 3 cycles.

Decomposition:
- Shared package mips_pipe_pkg:
  - REG_W.
  - FWD_RF=2'b00, FWD_EXE=2'b01, FWD_MEM=2'b10, FWD_LOAD=2'b11.
  - Packed struct dest_entry_t {dest, wreg, m2reg}.
- One sub-module is natural: fwd_sel. It is a pure combinational comparator taking one source index and the EX/MEM entries, and returning a 2-bit select plus an EX-load-hit flag. It is instantiated twice (rs, rt).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with id_wreg=1, id_dest_reg=5 -> wb_wreg=0, all dests 0, stall=0, fwd=00 throughout.
- Back-to-back ALU: add writes $8, next instruction reads rs=$8 -> fwd_a=01. The one after reads rt=$8 -> fwd_b=10. At the 3rd cycle wb_dest=8 and wb_wreg=1.
- Load-use: lw to $9 then rs=$9 used -> stall=1 for exactly one cycle, EX gets a bubble, next cycle fwd_a=11 and stall=0.
- $0 guard: an instruction writes dest=0 with wreg=1, followed by a reader of $0 -> fwd=00, no stall.
- Priority: MEM and EX both write $3, reader rs=$3 -> fwd_a=01 (EX wins). With EX as a load to $3 -> stall=1.
- Flush: ex_flush=1 on a lw to $4 followed by a reader of $4 -> no stall, fwd=00, and no write of $4 three cycles later.
